muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; only 16 is supported.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  1  0=MUL (unsigned), 1=DIV (unsigned).
REQ-006 a, b  input  16 each  multiplicand/dividend, multiplier/divisor; latched on accepted start.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  one-cycle pulse in DONE state.
REQ-009 result_lo, result_hi  output  16 each  MUL: product low/high; DIV: quotient/remainder.
REQ-010 div_by_zero  output  1  set with done when a DIV had b==0.
REQ-011 alu_op  output  3  op code to the shared external alu; alu_a, alu_b  output  16 each  its operands.
REQ-012 alu_out  input  16 and alu_carry  input  1  alu result; carry is carry-out on ADD and borrow (b>a) on SUB.

Function
REQ-013 States SHALL be IDLE, MUL, DIV, DONE; a 4-bit iteration counter SHALL count 0..15.
REQ-014 IDLE to MUL on start && op==0; IDLE to DIV on start && op==1 && b!=0; IDLE to DONE on start && op==1 && b==0.
REQ-015 MUL and DIV SHALL each run exactly 16 cycles, one per iteration, then go to DONE; DONE SHALL go to IDLE after one cycle.
REQ-016 Latency: start accepted at edge N; done high in cycle N+17 for MUL/DIV, and in cycle N+1 for divide-by-zero.
REQ-017 start outside IDLE, including in DONE, SHALL be ignored; operands SHALL not be re-latched while busy.
REQ-018 MUL init: hi=0, lo=a, mcand=b; per cycle alu_op=ALU_ADD, alu_a=hi, alu_b=(lo[0] ? mcand : 0); {hi,lo} <= {alu_carry, alu_out, lo[15:1]}.
REQ-019 DIV init: r=0, q=a, dvsr=b; per cycle form {ob, r'} = {r, q[15]}, alu_op=ALU_SUB, alu_a=r', alu_b=dvsr.
REQ-020 DIV per-cycle update: if ob || !alu_carry then r<=alu_out and shift 1 into q, else r<=r' and shift 0 into q.
REQ-021 Divide-by-zero SHALL produce result_lo=0xFFFF, result_hi=a, div_by_zero=1.
REQ-022 result_lo/result_hi SHALL update only on entry to DONE and hold until the next DONE; div_by_zero SHALL clear on the next accepted start.
REQ-023 In IDLE and DONE, alu_op SHALL be ALU_ADD with alu_a=alu_b=0.
REQ-024 All arithmetic SHALL be modulo 2^16 except the 17-bit carry/ob paths stated above.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, counter 0, busy=0, done=0, div_by_zero=0, results and all internal registers 0.
REQ-026 Reset mid-operation SHALL abandon the operation with no done pulse; the first start after release SHALL proceed normally.

Configuration
REQ-027 Macro MULDIV_SEQ_DIV_EN defined: DIV state, divide datapath and div_by_zero logic SHALL be present as specified.
REQ-028 Macro MULDIV_SEQ_DIV_EN undefined: no DIV state; start with op==1 SHALL be ignored (busy stays 0); div_by_zero SHALL be tied 0.

Structure
REQ-029 ALU op codes (ALU_ADD, ALU_SUB) SHALL come from the shared constants; the MUL/DIV op encoding and the state enum SHALL be added there.
REQ-030 The alu SHALL be instantiated by the parent and shared through the alu_* ports; muldiv_seq SHALL have no sub-modules.

Verification
REQ-031 MUL a=0x1234, b=0x5678 -> done at N+17; hi=0x0626, lo=0x0060.
REQ-032 MUL a=0xFFFF, b=0xFFFF -> hi=0xFFFE, lo=0x0001 (carry path).
REQ-033 DIV a=1000, b=7 -> quotient 0x008E, remainder 0x0006, div_by_zero=0.
REQ-034 DIV a=0xFFFF, b=0x8001 -> quotient 0x0001, remainder 0x7FFE (17-bit partial remainder path).
REQ-035 DIV a=0x0042, b=0 -> done at N+1; quotient 0xFFFF, remainder 0x0042, div_by_zero=1.
REQ-036 Start MUL, pulse start again at N+5, assert rst_n low at N+8 -> second start ignored, no done, all outputs 0; next MUL 3*5 -> lo=0x000F.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared constants for muldiv_seq: alu op codes, MUL/DIV op encoding and FSM state enum.
// The DIV state exists only when MULDIV_SEQ_DIV_EN is defined.
package muldiv_seq_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_t;

`ifdef MULDIV_SEQ_DIV_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd3
  } state_t;
`endif

  localparam int              ITER_W    = 4;
  localparam logic [ITER_W-1:0] ITER_LAST = 4'd15;

endpackage

// File: rtl/muldiv_seq.sv
// Sequential 16-bit unsigned multiply / divide, one bit per cycle on a shared external alu.
// Optional divide support enabled by MULDIV_SEQ_DIV_EN.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry
);

  state_t              state;
  logic [ITER_W-1:0]   iter_cnt;
  // MUL and DIV share the same registers: hi/remainder, lo/quotient, multiplicand/divisor.
  logic [WIDTH-1:0]    acc_hi;
  logic [WIDTH-1:0]    acc_lo;
  logic [WIDTH-1:0]    opnd_b;
  logic [WIDTH-1:0]    hi_nxt;
  logic [WIDTH-1:0]    lo_nxt;

`ifdef MULDIV_SEQ_DIV_EN
  logic                div_ob;
  logic [WIDTH-1:0]    div_rem_sh;

  // 17-bit partial remainder {ob, r'}: the bit shifted out of r must count in the compare.
  assign div_ob     = acc_hi[WIDTH-1];
  assign div_rem_sh = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = '0;
    alu_b  = '0;
    hi_nxt = acc_hi;
    lo_nxt = acc_lo;
    case (state)
      ST_MUL: begin
        alu_op           = ALU_ADD;
        alu_a            = acc_hi;
        alu_b            = acc_lo[0] ? opnd_b : '0;
        {hi_nxt, lo_nxt} = {alu_carry, alu_out, acc_lo[WIDTH-1:1]};
      end
`ifdef MULDIV_SEQ_DIV_EN
      ST_DIV: begin
        alu_op = ALU_SUB;
        alu_a  = div_rem_sh;
        alu_b  = opnd_b;
        if (div_ob || !alu_carry) begin
          hi_nxt = alu_out;
          lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
          hi_nxt = div_rem_sh;
          lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
        end
      end
`endif
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      iter_cnt    <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd_b      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && (op == OP_MUL)) begin
            state       <= ST_MUL;
            busy        <= 1'b1;
            iter_cnt    <= '0;
            acc_hi      <= '0;
            acc_lo      <= a;
            opnd_b      <= b;
            div_by_zero <= 1'b0;
          end
`ifdef MULDIV_SEQ_DIV_EN
          else if (start && (b == '0)) begin
            // Divide by zero finishes immediately with saturated quotient and dividend as remainder.
            state       <= ST_DONE;
            busy        <= 1'b1;
            done        <= 1'b1;
            result_lo   <= '1;
            result_hi   <= a;
            div_by_zero <= 1'b1;
          end else if (start) begin
            state       <= ST_DIV;
            busy        <= 1'b1;
            iter_cnt    <= '0;
            acc_hi      <= '0;
            acc_lo      <= a;
            opnd_b      <= b;
            div_by_zero <= 1'b0;
          end
`endif
        end

`ifdef MULDIV_SEQ_DIV_EN
        ST_MUL, ST_DIV: begin
`else
        ST_MUL: begin
`endif
          acc_hi   <= hi_nxt;
          acc_lo   <= lo_nxt;
          iter_cnt <= iter_cnt + 1'b1;
          if (iter_cnt == ITER_LAST) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            result_lo <= lo_nxt;
            result_hi <= hi_nxt;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
